// File: rtl/uart_burst_sys_ctrl.sv
// UART command bridge: single/burst memory read/write plus CPU reset control.
// Define UART_CSUM_EN to add burst checksum bytes and write acknowledges.
//
//   state | meaning
//   IDLE  | waiting for a command byte
//   ADDR  | collecting address bytes, MSB first
//   LEN   | collecting burst length byte (L+1 data bytes)
//   WDATA | waiting for the next write data byte
//   MWR   | mem_we pulse cycle, advance address
//   MRD   | issue mem_re
//   RWAIT | read latency countdown, capture mem_rdata
//   TXS   | wait for transmitter idle, pulse tx_start
//   TXW   | wait for tx_done
//   CSUM  | burst checksum: receive/compare (write) or send (read)
module uart_burst_sys_ctrl #(
  parameter int ADDR_BYTES  = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [7:0]              mem_rdata,
  output logic                    cpu_rst,
  output logic                    busy,
  output logic                    err
);

  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int AC_W   = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, MWR, MRD, RWAIT, TXS, TXW
`ifdef UART_CSUM_EN
    , CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d, burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [AC_W-1:0]   acnt_q, acnt_d;
  logic [7:0]        len_q, len_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [2:0]        lat_q, lat_d;
  logic              tx_start_q, tx_start_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [7:0]        tx_data_q, tx_data_d, mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d, cpu_rst_q, cpu_rst_d, busy_q, busy_d;
  logic              awaiting;
`ifdef UART_CSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              ack_q, ack_d;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    acnt_d      = acnt_q;
    len_d       = len_q;
    lat_d       = lat_q;
    tx_data_d   = tx_data_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    tx_start_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    err_d       = 1'b0;
`ifdef UART_CSUM_EN
    csum_d      = csum_q;
    ack_d       = ack_q;
`endif
    awaiting = (state_q == ADDR) || (state_q == LEN) || (state_q == WDATA);
`ifdef UART_CSUM_EN
    if (state_q == CSUM && wr_q) awaiting = 1'b1;
`endif
    // Idle-byte timer restarts whenever a byte is taken or we are not listening.
    tmo_d = (awaiting && !rx_valid) ? tmo_q - TMO_W'(1) : TMO_LOAD;

    case (state_q)
      IDLE: if (rx_valid) begin
        case (rx_data)
          8'h02, 8'h03, 8'h04, 8'h05: begin
            wr_d    = ~rx_data[0];
            burst_d = rx_data[2];
            acnt_d  = AC_W'(ADDR_BYTES - 1);
            len_d   = 8'd0;
`ifdef UART_CSUM_EN
            csum_d  = 8'd0;
            ack_d   = 1'b0;
`endif
            state_d = ADDR;
          end
          8'h06:   cpu_rst_d = 1'b1;
          8'h07:   cpu_rst_d = 1'b0;
          default: err_d = 1'b1;
        endcase
      end
      ADDR: if (rx_valid) begin
        addr_d = (addr_q << 8) | ADDR_W'(rx_data);
        if (acnt_q == '0) state_d = burst_q ? LEN : (wr_q ? WDATA : MRD);
        else acnt_d = acnt_q - AC_W'(1);
      end
      LEN: if (rx_valid) begin
        len_d   = rx_data;
        state_d = wr_q ? WDATA : MRD;
      end
      WDATA: if (rx_valid) begin
        mem_wdata_d = rx_data;
        mem_we_d    = 1'b1;
`ifdef UART_CSUM_EN
        csum_d      = csum_q ^ rx_data;
`endif
        state_d     = MWR;
      end
      MWR: begin
        addr_d = addr_q + ADDR_W'(1);
        if (len_q == 8'd0) begin
          state_d = IDLE;
`ifdef UART_CSUM_EN
          if (burst_q) state_d = CSUM;
`endif
        end else begin
          len_d   = len_q - 8'd1;
          state_d = WDATA;
        end
      end
      MRD: begin
        mem_re_d = 1'b1;
        lat_d    = 3'(RD_LAT);
        state_d  = RWAIT;
      end
      // lat_q reaches zero exactly RD_LAT cycles after the mem_re cycle.
      RWAIT: if (lat_q == 3'd0) begin
        tx_data_d = mem_rdata;
`ifdef UART_CSUM_EN
        csum_d    = csum_q ^ mem_rdata;
`endif
        state_d   = TXS;
      end else begin
        lat_d = lat_q - 3'd1;
      end
      TXS: if (!tx_active) begin
        tx_start_d = 1'b1;
        state_d    = TXW;
      end
      TXW: if (tx_done) begin
        if (len_q == 8'd0) begin
          state_d = IDLE;
`ifdef UART_CSUM_EN
          if (burst_q && !ack_q) state_d = CSUM;
`endif
        end else begin
          len_d   = len_q - 8'd1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = MRD;
        end
      end
`ifdef UART_CSUM_EN
      CSUM: begin
        if (wr_q) begin
          if (rx_valid) begin
            tx_data_d = (rx_data == csum_q) ? 8'hAA : 8'h55;
            err_d     = (rx_data != csum_q);
            ack_d     = 1'b1;
            state_d   = TXS;
          end
        end else begin
          tx_data_d = csum_q;
          ack_d     = 1'b1;
          state_d   = TXS;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (awaiting && !rx_valid && tmo_q == '0) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      burst_q     <= 1'b0;
      addr_q      <= '0;
      acnt_q      <= '0;
      len_q       <= 8'd0;
      tmo_q       <= '0;
      lat_q       <= 3'd0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_CSUM_EN
      csum_q      <= 8'd0;
      ack_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      acnt_q      <= acnt_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      lat_q       <= lat_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      err_q       <= err_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
`ifdef UART_CSUM_EN
      csum_q      <= csum_d;
      ack_q       <= ack_d;
`endif
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_burst_sys_ctrl.sv
// Scoreboard bench for uart_burst_sys_ctrl: memory and UART-TX models on the
// falling edge, expected writes/reads/TX bytes queued by each scenario task.
module tb_uart_burst_sys_ctrl;
  localparam int ADDR_BYTES  = 2;
  localparam int RD_LAT      = 2;
  localparam int TIMEOUT_CYC = 40;
  localparam int TX_CYC      = 6;
`ifdef UART_CSUM_EN
  localparam int CS_EN = 1;
`else
  localparam int CS_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic        tx_done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        cpu_rst;
  logic        busy;
  logic        err;

  uart_burst_sys_ctrl #(
    .ADDR_BYTES(ADDR_BYTES), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cpu_rst(cpu_rst), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  mem_model [0:65535];

  int checks = 0, errors = 0, err_cnt = 0, tx_cnt = 0;
  int rd_cnt = 0, tx_left = 0;
  logic [7:0]  rd_val, mb;
  logic [15:0] ma;
  wr_t         mw;

  // Falling-edge models: memory read pipeline, UART transmitter, output monitor.
  initial begin
    tx_active = 1'b0; tx_done = 1'b0; mem_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        mem_rdata = (rd_cnt == 0) ? rd_val : 8'hEE;
      end else mem_rdata = 8'hEE;
      if (err === 1'b1) err_cnt++;
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL mem_we_unexpected: addr=%h data=%h, required no write", mem_addr, mem_wdata);
        end else begin
          mw = exp_wr.pop_front();
          if (mem_addr !== mw.a || mem_wdata !== mw.d) begin
            errors++;
            $display("FAIL mem_write: addr=%h data=%h, required addr=%h data=%h", mem_addr, mem_wdata, mw.a, mw.d);
          end
        end
      end
      if (mem_re === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL mem_re_unexpected: addr=%h, required no read", mem_addr);
        end else begin
          ma = exp_rd.pop_front();
          if (mem_addr !== ma) begin
            errors++;
            $display("FAIL mem_read_addr: addr=%h, required %h", mem_addr, ma);
          end
        end
        rd_cnt = RD_LAT;
        rd_val = mem_model[mem_addr];
      end
      if (tx_start === 1'b1) begin
        tx_cnt++;
        checks++;
        if (tx_active !== 1'b0) begin
          errors++;
          $display("FAIL tx_start_while_active: tx_active=%b, required 0", tx_active);
        end
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: tx_data=%h, required no byte", tx_data);
        end else begin
          mb = exp_tx.pop_front();
          if (tx_data !== mb) begin
            errors++;
            $display("FAIL tx_data: got %h, required %h", tx_data, mb);
          end
        end
        tx_active = 1'b1;
        tx_left   = TX_CYC;
      end else if (tx_active) begin
        tx_left--;
        if (tx_left == 0) begin
          tx_active = 1'b0;
          tx_done   = 1'b1;
        end
      end
    end
  end

  task automatic send_raw(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || tx_active || exp_wr.size() > 0 || exp_rd.size() > 0 ||
            exp_tx.size() > 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL %s_drain: busy=%b pending wr=%0d rd=%0d tx=%0d, required all done",
               name, busy, exp_wr.size(), exp_rd.size(), exp_tx.size());
      exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    end
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({tx_start, mem_we, mem_re, err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: {tx_start,we,re,err,busy}=%b, required 00000",
               {tx_start, mem_we, mem_re, err, busy});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 8'h0 || tx_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h tx_data=%h, required 0", mem_addr, mem_wdata, tx_data);
    end
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_cpu_rst: got %b, required 1", cpu_rst);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cpu_rst=%b busy=%b, required 1 0", cpu_rst, busy);
    end
  endtask

  task automatic test_single_write();
    int e0, t0;
    e0 = err_cnt; t0 = tx_cnt;
    exp_wr.push_back({16'h8000, 8'h5A});
    send_byte(8'h02); send_byte(8'h80); send_byte(8'h00); send_byte(8'h5A);
    wait_idle("single_write");
    checks++;
    if (tx_cnt !== t0 || err_cnt !== e0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL single_write_side: tx=%0d err=%0d cpu_rst=%b, required 0 0 1",
               tx_cnt - t0, err_cnt - e0, cpu_rst);
    end
  endtask

  task automatic test_single_read();
    int t0;
    t0 = tx_cnt;
    mem_model[16'h0010] = 8'h3C;
    exp_rd.push_back(16'h0010);
    exp_tx.push_back(8'h3C);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10);
    wait_idle("single_read");
    checks++;
    if (tx_cnt !== t0 + 1) begin
      errors++;
      $display("FAIL single_read_tx_count: got %0d, required 1", tx_cnt - t0);
    end
  endtask

  task automatic test_burst_write_wrap();
    logic [7:0]  d [4];
    logic [7:0]  cs;
    logic [15:0] a;
    int e0, t0;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    e0 = err_cnt; t0 = tx_cnt; cs = 8'h00; a = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back({a, d[i]});
      a = a + 16'd1;
      cs = cs ^ d[i];
    end
    send_byte(8'h04); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h03);
    for (int i = 0; i < 4; i++) send_byte(d[i]);
`ifdef UART_CSUM_EN
    exp_tx.push_back(8'hAA);
    send_byte(cs);
`endif
    wait_idle("burst_write");
    checks++;
    if (tx_cnt !== t0 + CS_EN || err_cnt !== e0) begin
      errors++;
      $display("FAIL burst_write_side: tx=%0d err=%0d, required %0d 0", tx_cnt - t0, err_cnt - e0, CS_EN);
    end
  endtask

`ifdef UART_CSUM_EN
  task automatic test_csum_mismatch();
    int e0;
    e0 = err_cnt;
    exp_wr.push_back({16'h4000, 8'h5A});
    exp_tx.push_back(8'h55);
    send_byte(8'h04); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'h00);
    wait_idle("csum_mismatch");
    checks++;
    if (err_cnt !== e0 + 1) begin
      errors++;
      $display("FAIL csum_mismatch_err: got %0d pulses, required 1", err_cnt - e0);
    end
  endtask
`endif

  task automatic test_burst_read();
    logic [7:0] d [3];
    logic [7:0] cs;
    int e0, t0;
    d = '{8'h01, 8'h02, 8'h04};
    e0 = err_cnt; t0 = tx_cnt; cs = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mem_model[16'h2000 + 16'(i)] = d[i];
      exp_rd.push_back(16'h2000 + 16'(i));
      exp_tx.push_back(d[i]);
      cs = cs ^ d[i];
    end
`ifdef UART_CSUM_EN
    exp_tx.push_back(cs);
`endif
    send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    send_raw(8'h02);
    idle(6);
    send_raw(8'h07);
    wait_idle("burst_read");
    checks++;
    if (tx_cnt !== t0 + 3 + CS_EN) begin
      errors++;
      $display("FAIL burst_read_tx_count: got %0d, required %0d", tx_cnt - t0, 3 + CS_EN);
    end
    checks++;
    if (cpu_rst !== 1'b1 || err_cnt !== e0) begin
      errors++;
      $display("FAIL burst_read_ignore_rx: cpu_rst=%b err=%0d, required 1 0", cpu_rst, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int n, e0, t0;
    e0 = err_cnt;
    send_raw(8'h02); send_raw(8'h80);
    n = 0;
    while (busy === 1'b1 && n < TIMEOUT_CYC + 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TIMEOUT_CYC) begin
      errors++;
      $display("FAIL timeout_cycles: busy fell after %0d, required %0d", n, TIMEOUT_CYC);
    end
    idle(1);
    checks++;
    if (err_cnt !== e0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%0d busy=%b, required 1 0", err_cnt - e0, busy);
    end
    // A byte landing on the expiring cycle is taken.
    e0 = err_cnt;
    exp_wr.push_back({16'h8000, 8'hC3});
    send_raw(8'h02); idle(TIMEOUT_CYC - 2); send_raw(8'h80);
    send_byte(8'h00); send_byte(8'hC3);
    wait_idle("timeout_edge");
    checks++;
    if (err_cnt !== e0) begin
      errors++;
      $display("FAIL timeout_edge_err: got %0d pulses, required 0", err_cnt - e0);
    end
    // One cycle later it is too late: timeout, then the byte is a bad command.
    e0 = err_cnt;
    send_raw(8'h02); idle(TIMEOUT_CYC - 1); send_raw(8'h80);
    idle(3);
    checks++;
    if (err_cnt !== e0 + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late: err=%0d busy=%b, required 2 0", err_cnt - e0, busy);
    end
    send_raw(8'h99);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd: err=%b busy=%b, required 1 0", err, busy);
    end
    t0 = tx_cnt;
    send_raw(8'h07);
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rst_release1: got %b, required 0", cpu_rst);
    end
    send_raw(8'h06);
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL cpu_rst_assert: got %b, required 1", cpu_rst);
    end
    send_raw(8'h07);
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rst_release2: got %b, required 0", cpu_rst);
    end
    idle(3);
    checks++;
    if (tx_cnt !== t0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_rst_no_tx: tx=%0d busy=%b, required 0 0", tx_cnt - t0, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int e0;
    exp_wr.push_back({16'h3000, 8'hA1});
    exp_wr.push_back({16'h3001, 8'hA2});
    send_byte(8'h04); send_byte(8'h30); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hA1); send_byte(8'hA2);
    checks++;
    if (exp_wr.size() !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst_pre: pending=%0d busy=%b, required 0 1", exp_wr.size(), busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_start, mem_we, mem_re, err, busy} !== 5'b0 || cpu_rst !== 1'b1 ||
        mem_addr !== 16'h0 || mem_wdata !== 8'h0 || tx_data !== 8'h0) begin
      errors++;
      $display("FAIL mid_burst_reset: strobes=%b cpu_rst=%b addr=%h wdata=%h tx=%h, required 0s cpu_rst=1",
               {tx_start, mem_we, mem_re, err, busy}, cpu_rst, mem_addr, mem_wdata, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    e0 = err_cnt;
    send_byte(8'hA3); send_byte(8'hA4);
    checks++;
    if (err_cnt !== e0 + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_burst_after: err=%0d busy=%b, required 2 0", err_cnt - e0, busy);
    end
    exp_wr.push_back({16'h1234, 8'h56});
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    wait_idle("post_reset_write");
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write_wrap();
`ifdef UART_CSUM_EN
    test_csum_mismatch();
`endif
    test_burst_read();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
